// File: rtl/function_right_shift.sv
// function_right_shift: a registered right-shift unit with logical, arithmetic
// and rotate modes and a one-cycle latency. It also exposes the combinational
// helper function rshift, which other scopes can call hierarchically.
module function_right_shift #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   shamt,
    input  logic [1:0]       mode,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry
);

    typedef enum logic [1:0] {
        MODE_LSR = 2'b00,
        MODE_ASR = 2'b01,
        MODE_ROR = 2'b10,
        MODE_RSV = 2'b11   // reserved code, decoded as logical
    } mode_e;

    // One-bit logical right shift. It is pure and depends on no port or state,
    // so callers can use it as <inst>.rshift(x).
    function automatic logic [WIDTH-1:0] rshift(input logic [WIDTH-1:0] d);
        return {1'b0, d[WIDTH-1:1]};
    endfunction

    mode_e            mode_sel;
    logic [31:0]      k_full;    // shift amount widened for the arithmetic
    logic [31:0]      k_rot;     // rotate amount, reduced modulo WIDTH
    logic [31:0]      k_last;    // 1-based index of the last bit shifted out, 0 = none
    logic [WIDTH-1:0] res_d;
    logic             carry_d;

    assign mode_sel = mode_e'(mode);

    // Compute the next result and carry from the current operand.
    // NOTE: every variable gets a default value at the top of the block.
    // This keeps a branch that skips an assignment from inferring a latch.
    always_comb begin
        k_full  = 32'(shamt);
        k_rot   = k_full % 32'(WIDTH);
        // Logical and arithmetic shifts drop every bit once k >= WIDTH.
        // In that case the last bit shifted out is the MSB.
        k_last  = (k_full >= 32'(WIDTH)) ? 32'(WIDTH) : k_full;
        res_d   = in_data >> k_full;
        carry_d = 1'b0;
        case (mode_sel)
            MODE_ASR: res_d = $signed(in_data) >>> k_full;
            MODE_ROR: begin
                // When k_rot is 0, the left shift is by WIDTH and yields 0.
                // The result is then in_data itself.
                res_d  = (in_data >> k_rot) | (in_data << (32'(WIDTH) - k_rot));
                k_last = k_rot;
            end
            default: res_d = in_data >> k_full;   // MODE_LSR and MODE_RSV
        endcase
        for (int i = 0; i < WIDTH; i++) begin
            if (k_last == 32'(i + 1)) carry_d = in_data[i];
        end
    end

    // Capture the result on each valid operand. Data and carry hold between operands.
    // NOTE: registers are written with non-blocking assignments.
    // All flops then update together at the edge, whatever order they are written in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_carry <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data  <= res_d;
                out_carry <= carry_d;
            end
        end
    end

endmodule

// File: tb/tb_function_right_shift.sv
// Scoreboard bench for function_right_shift.
// It uses two instances: WIDTH=8 (a power of two) and WIDTH=5 (where shamt can
// reach or exceed WIDTH). Expected results come from an arithmetic reference model.
module tb_function_right_shift;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data8;
    logic [4:0] in_data5;
    logic [2:0] shamt;
    logic [1:0] mode;
    logic       out_valid8, out_valid5;
    logic [7:0] out_data8;
    logic [4:0] out_data5;
    logic       out_carry8, out_carry5;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int data;
        int carry;
    } exp_t;

    exp_t q8[$];
    exp_t q5[$];

    function_right_shift #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data8),
        .shamt(shamt), .mode(mode), .out_valid(out_valid8), .out_data(out_data8),
        .out_carry(out_carry8)
    );

    function_right_shift #(.WIDTH(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data5),
        .shamt(shamt), .mode(mode), .out_valid(out_valid5), .out_data(out_data5),
        .out_carry(out_carry5)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model, computed with integer arithmetic.
    // d is unsigned, w bits wide, and k is the raw shift amount.
    function automatic exp_t model(input int w, input int d, input int k, input int m);
        exp_t e;
        int   pw;
        int   v;
        int   r;
        int   kk;
        pw = 1 << w;
        kk = (k >= w) ? w : k;
        e.carry = (kk == 0) ? 0 : (d / (1 << (kk - 1))) % 2;
        if (m == 2) begin
            r       = k % w;
            e.data  = (d % (1 << r)) * (1 << (w - r)) + d / (1 << r);
            e.carry = (r == 0) ? 0 : (d / (1 << (r - 1))) % 2;
        end else if (m == 1) begin
            v = (d >= pw / 2) ? d - pw : d;
            // Floor division by 2^kk. For kk = w this gives 0 or -1, which is all sign bits.
            if (v < 0) v = -((-v + (1 << kk) - 1) / (1 << kk));
            else       v = v / (1 << kk);
            e.data = (v + pw) % pw;
        end else begin
            e.data = (k >= w) ? 0 : d / (1 << k);
        end
        return e;
    endfunction

    // Drive one operand and queue the expected results.
    // When valid is 0, this drives an idle cycle instead.
    task automatic drive(input bit valid, input int d8, input int d5, input int k, input int m);
        in_valid = valid;
        in_data8 = 8'(d8);
        in_data5 = 5'(d5);
        shamt    = 3'(k);
        mode     = 2'(m);
        if (valid) begin
            q8.push_back(model(8, d8, k, m));
            q5.push_back(model(5, d5, k, m));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Monitor: compare each presented result against the scoreboard.
    // In idle cycles, check that data and carry hold their last values.
    initial begin : monitor
        int   last8;
        int   last5;
        int   lc8;
        int   lc5;
        exp_t e;
        last8 = 0; last5 = 0; lc8 = 0; lc5 = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last8 = 0; last5 = 0; lc8 = 0; lc5 = 0;
            end else begin
                if (out_valid8) begin
                    if (q8.size() == 0) check("w8 unexpected out_valid", 1, 0);
                    else begin
                        e = q8.pop_front();
                        check("w8 out_data", int'(out_data8), e.data);
                        check("w8 out_carry", int'(out_carry8), e.carry);
                    end
                end else begin
                    check("w8 hold data", int'(out_data8), last8);
                    check("w8 hold carry", int'(out_carry8), lc8);
                end
                if (out_valid5) begin
                    if (q5.size() == 0) check("w5 unexpected out_valid", 1, 0);
                    else begin
                        e = q5.pop_front();
                        check("w5 out_data", int'(out_data5), e.data);
                        check("w5 out_carry", int'(out_carry5), e.carry);
                    end
                end else begin
                    check("w5 hold data", int'(out_data5), last5);
                    check("w5 hold carry", int'(out_carry5), lc5);
                end
                last8 = int'(out_data8); lc8 = int'(out_carry8);
                last5 = int'(out_data5); lc5 = int'(out_carry5);
            end
        end
    end

    // Directed operands: {d8, d5, k, mode}
    int dir_tab[13][4] = '{
        '{8'hB3, 5'h13, 1, 0}, '{8'hB3, 5'h13, 3, 0},
        '{8'hB3, 5'h13, 1, 1}, '{8'hB3, 5'h13, 7, 1}, '{8'h70, 5'h0E, 4, 1},
        '{8'hB3, 5'h13, 3, 2}, '{8'hB3, 5'h13, 1, 2}, '{8'hB3, 5'h13, 0, 2},
        '{8'hB3, 5'h13, 3, 3}, '{8'hB3, 5'h16, 5, 0}, '{8'h5A, 5'h16, 6, 1},
        '{8'h5A, 5'h16, 7, 2}, '{8'h5A, 5'h1F, 5, 2}
    };

    initial begin : stim
        int wait_cycles;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data8 = '0;
        in_data5 = '0;
        shamt    = '0;
        mode     = '0;
        #1;
        check("reset out_valid", int'(out_valid8), 0);
        check("reset out_data", int'(out_data8), 0);
        check("reset out_carry", int'(out_carry8), 0);

        // Combinational helper, called hierarchically.
        check("rshift B3", int'(dut8.rshift(8'b10110011)), 8'b01011001);
        check("rshift 01", int'(dut8.rshift(8'h01)), 8'h00);
        check("rshift FF", int'(dut8.rshift(8'hFF)), 8'h7F);

        // in_valid is high across an edge while still in reset. It must be ignored.
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data8 = 8'hB3;
        @(posedge clk);
        #1;
        check("valid in reset ignored", int'(out_valid8), 0);
        in_valid = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases: sent back-to-back, then with gaps.
        foreach (dir_tab[i]) drive(1'b1, dir_tab[i][0], dir_tab[i][1], dir_tab[i][2], dir_tab[i][3]);
        drive(1'b0, 0, 0, 0, 0);
        drive(1'b1, 8'hC4, 5'h09, 2, 0);
        drive(1'b0, 0, 0, 0, 0);
        drive(1'b0, 0, 0, 0, 0);
        drive(1'b1, 8'hC4, 5'h09, 2, 3);

        // Randomized traffic with random idle gaps.
        for (int n = 0; n < 300; n++) begin
            drive(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 255)), int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
        end

        // Assert reset mid-cycle while a result is pending.
        drive(1'b1, 8'hFF, 5'h1F, 1, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async reset out_valid", int'(out_valid8), 0);
        check("async reset out_data", int'(out_data8), 0);
        check("async reset out_carry", int'(out_carry8), 0);
        check("async reset w5 out_data", int'(out_data5), 0);
        q8.delete();
        q5.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b1, 8'hB3, 5'h13, 3, 2);
        drive(1'b0, 0, 0, 0, 0);

        wait_cycles = 0;
        while ((q8.size() != 0 || q5.size() != 0) && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        check("scoreboard drained w8", q8.size(), 0);
        check("scoreboard drained w5", q5.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
